spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//   System-clock-domain SPI write controller for the peripheral configuration register bank.
//   - Oversamples sclk/copi/ncs, assembles 16-bit write frames and range-checks the address.
//   - Commits each valid frame atomically, in one clk cycle, after ncs deasserts.
//   - Downstream logic (PWM, output enables) reads only glitch-free, clk-aligned register values.
// PARAMETERS
//   NUM_REGS     5   number of implemented 8-bit registers (addresses 0..NUM_REGS-1)
//   ADDR_W       7   address field width in frame
//   DATA_W       8   data field width in frame
//   SYNC_STAGES  2   flip-flop stages in each input synchronizer (>=2)
// PORTS
//   clk        in   1                system clock; all state on posedge
//   rst        in   1                asynchronous, active-high reset
//   sclk       in   1                SPI clock, async to clk, mode 0, f_sclk <= f_clk/4
//   copi       in   1                SPI data in, MSB first
//   ncs        in   1                SPI chip select, active low
//   reg_out    out  NUM_REGS*DATA_W  register bank, reg N at [N*DATA_W +: DATA_W]
//   wr_strobe  out  1                one-cycle pulse on each commit
//   wr_addr    out  ADDR_W           address of last commit (held)
//   wr_data    out  DATA_W           data of last commit (held)
//   frame_err  out  1                one-cycle pulse when a write frame is rejected
//   txn_count  out  8                committed-write counter
// BEHAVIOUR
//   - Reset: all outputs 0; FSM to IDLE; shift reg/bit count cleared. Reset mid-frame abandons frame, no commit.
//   - Inputs pass SYNC_STAGES-FF sync; rise/fall detect on synced value vs one extra delayed copy.
//   - Frame: bit15 = R/W (1 = write), bits14:8 = addr, bits7:0 = data; copi sampled on sclk rise.
//   - FSM IDLE: ncs fall -> SHIFT, clear bit_cnt; sclk edges while ncs high ignored.
//   - FSM SHIFT: each sclk rise shifts copi in, bit_cnt++ (saturates at 17).
//   - SHIFT, ncs rise: write frame with bit_cnt==16 and addr<NUM_REGS -> COMMIT.
//   - SHIFT, ncs rise: read frame with bit_cnt==16 -> IDLE silently, no error.
//   - SHIFT, ncs rise: otherwise (bit_cnt!=16, or write with addr>=NUM_REGS) -> IDLE + frame_err pulse.
//   - COMMIT (1 cycle): reg[addr]<=data; wr_addr/wr_data updated; wr_strobe=1; txn_count++ -> IDLE.
//   - Other registers unchanged on commit.
//   - Latency: reg_out updates <= SYNC_STAGES+3 clk after raw ncs rise. No partial value ever visible.
//   - Simultaneous: sclk rise and ncs rise detected in same cycle: ncs rise wins, sample dropped.
//   - Simultaneous: ncs fall in COMMIT is handled in IDLE next cycle; min ncs-high of 4 clk required.
//   - txn_count wraps 255 -> 0. frame_err and wr_strobe never assert in the same cycle.
// STRUCTURE
//   - Package spi_pkg: FRAME_BITS=16, RW_BIT=15, state encoding (IDLE/SHIFT/COMMIT), register address constants.
//   - Sub-module sync_edge_det: SYNC_STAGES sync plus rise/fall pulses; 3 instances (sclk, copi, ncs).
//   - copi instance uses level output only.
//   - Top holds FSM, 16-bit shift reg, 5-bit bit_cnt, register array, counter.
// TESTING
//   1. Reset, then write frame 0x8155 -> reg1=0x55, wr_strobe 1 cycle, txn_count=1, other regs 0.
//   2. Frame 0x8500 (addr 5) -> frame_err pulse, reg_out unchanged, txn_count unchanged.
//   3. Frame 0x0277 (read) -> no strobe, no frame_err, regs unchanged.
//   4. Only 12 bits then ncs high -> frame_err; next full frame 0x84A5 -> reg4=0xA5.
//   5. rst asserted after 8 bits of 0x83FF -> all regs 0; post-reset frame 0x83FF -> reg3=0xFF.
//   6. 256 valid writes -> txn_count wraps to 0; sclk toggling with ncs high -> no state change.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, FSM state encoding and register map for the SPI register-write controller.
package spi_pkg;

  localparam int unsigned ADDR_W_DEF  = 7;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned RW_BIT      = 15;
  localparam int unsigned BIT_CNT_W   = 5;
  localparam int unsigned BIT_CNT_SAT = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Peripheral register map; REG_COUNT is the number of implemented registers.
  typedef enum int unsigned {
    REG_PWM_DUTY   = 0,
    REG_PWM_PERIOD = 1,
    REG_OUT_EN     = 2,
    REG_OUT_POL    = 3,
    REG_CTRL       = 4,
    REG_COUNT      = 5
  } reg_idx_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, with combinational rise/fall pulses
// derived from the synchronized level against one extra delayed copy.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI write controller: oversamples the SPI pins in the clk domain, assembles 16-bit frames
// and commits valid writes to the register bank in a single clk cycle after ncs deasserts.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REGS    = REG_COUNT,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         frame_err,
  output logic [7:0]                   txn_count
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .rise_c(copi_rise), .fall_c(copi_fall)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_lvl), .rise_c(ncs_rise), .fall_c(ncs_fall)
  );

  logic unused_sync_outs;
  assign unused_sync_outs = sclk_lvl ^ sclk_fall ^ copi_rise ^ copi_fall ^ ncs_lvl;

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   fall_pend_q;

  logic                   frame_rw;
  logic [ADDR_W-1:0]      frame_addr;
  logic [DATA_W-1:0]      frame_data;

  assign frame_rw   = shift_q[RW_BIT];
  assign frame_addr = shift_q[DATA_W +: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];

  // A chip-select fall seen during COMMIT is remembered so IDLE can still open the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      fall_pend_q <= 1'b0;
      reg_out     <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_err   <= 1'b0;
      txn_count   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          fall_pend_q <= 1'b0;
          if (ncs_fall || fall_pend_q) begin
            state_q   <= ST_SHIFT;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            state_q <= ST_IDLE;
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
              if (frame_rw) begin
                if (frame_addr < ADDR_W'(NUM_REGS)) state_q <= ST_COMMIT;
                else                                frame_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_lvl};
            if (bit_cnt_q != BIT_CNT_W'(BIT_CNT_SAT)) bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == ADDR_W'(i)) reg_out[i*DATA_W +: DATA_W] <= frame_data;
          end
          wr_addr     <= frame_addr;
          wr_data     <= frame_data;
          wr_strobe   <= 1'b1;
          txn_count   <= txn_count + 8'd1;
          fall_pend_q <= ncs_fall;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized bench for spi_reg_ctrl against a frame-level reference model of the register bank.
module tb_spi_reg_ctrl;

  localparam int unsigned NR   = 5;
  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 8;
  localparam int unsigned SS   = 2;
  localparam int unsigned HALF = 2;

  logic              clk = 1'b0;
  logic              rst, sclk, copi, ncs;
  logic [NR*DW-1:0]  reg_out;
  logic              wr_strobe, frame_err;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [7:0]        txn_count;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [DW-1:0] m_regs [NR];
  int            m_txn, m_addr, m_data;

  spi_reg_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (frame_err) err_cnt++;
    if (wr_strobe && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_bank();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_txn = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives bits[nbits-1:0] MSB first in SPI mode 0; optionally closes the frame.
  task automatic send_bits(input logic [31:0] bits, input int nbits, input bit close);
    ncs = 1'b0;
    wait_clks(3);
    for (int b = nbits - 1; b >= 0; b--) begin
      copi = bits[b];
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
    if (close) begin
      ncs = 1'b1;
      wait_clks(SS + 6);
    end
  endtask

  task automatic run_frame(input logic [31:0] bits, input int nbits);
    int s0, e0, exp_s, exp_e, a;
    s0 = strobe_cnt; e0 = err_cnt;
    exp_s = 0; exp_e = 0;
    if (nbits != 16) exp_e = 1;
    else if (bits[15]) begin
      a = int'(bits[14:8]);
      if (a < NR) begin
        m_regs[a] = bits[7:0];
        m_txn = (m_txn + 1) % 256;
        m_addr = a; m_data = int'(bits[7:0]);
        exp_s = 1;
      end else exp_e = 1;
    end
    send_bits(bits, nbits, 1'b1);
    check("strobe_pulses", 64'(strobe_cnt - s0), 64'(exp_s));
    check("err_pulses", 64'(err_cnt - e0), 64'(exp_e));
    check("reg_out", 64'(reg_out), 64'(model_bank()));
    check("txn_count", 64'(txn_count), 64'(m_txn));
    check("wr_addr", 64'(wr_addr), 64'(m_addr));
    check("wr_data", 64'(wr_data), 64'(m_data));
  endtask

  initial begin
    int kind, nb;
    logic [31:0] fr;
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    model_reset();
    wait_clks(3);
    check("rst_reg_out", 64'(reg_out), 64'(0));
    check("rst_txn", 64'(txn_count), 64'(0));
    check("rst_strobe", 64'(wr_strobe), 64'(0));
    check("rst_err", 64'(frame_err), 64'(0));
    rst = 1'b0;
    wait_clks(SS + 4);
    check("post_rst_err", 64'(err_cnt), 64'(0));

    // Directed frames
    run_frame(32'h8155, 16);
    run_frame(32'h8500, 16);
    run_frame(32'h0277, 16);
    run_frame(32'h0ABC, 12);
    run_frame(32'h84A5, 16);
    run_frame(32'h1_80FF, 17);

    // Reset in the middle of a frame abandons it and clears the bank
    send_bits(32'h83, 8, 1'b0);
    rst = 1'b1;
    wait_clks(2);
    model_reset();
    check("midrst_reg_out", 64'(reg_out), 64'(0));
    check("midrst_txn", 64'(txn_count), 64'(0));
    rst = 1'b0;
    ncs = 1'b1;
    wait_clks(SS + 6);
    run_frame(32'h83FF, 16);

    // Random mix of valid writes, bad addresses, reads and bad lengths
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      fr = '0;
      nb = 16;
      case (kind)
        0: fr[15:0] = {1'b1, 7'($urandom_range(0, NR - 1)), 8'($urandom)};
        1: fr[15:0] = {1'b1, 7'($urandom_range(NR, 127)), 8'($urandom)};
        2: fr[15:0] = {1'b0, 15'($urandom)};
        default: begin
          fr = $urandom;
          nb = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 15) : $urandom_range(17, 20);
        end
      endcase
      run_frame(fr, nb);
    end

    // sclk activity with ncs high must be ignored
    begin
      int s0, e0;
      s0 = strobe_cnt; e0 = err_cnt;
      for (int t = 0; t < 20; t++) begin
        copi = 1'($urandom);
        sclk = ~sclk;
        wait_clks(HALF);
      end
      sclk = 1'b0;
      wait_clks(SS + 6);
      check("idle_sclk_strobe", 64'(strobe_cnt - s0), 64'(0));
      check("idle_sclk_err", 64'(err_cnt - e0), 64'(0));
      check("idle_sclk_regs", 64'(reg_out), 64'(model_bank()));
    end

    // 256 valid writes bring the counter back around to its starting value
    begin
      int start_txn;
      start_txn = m_txn;
      for (int n = 0; n < 256; n++)
        run_frame({16'h0, 1'b1, 7'($urandom_range(0, NR - 1)), 8'($urandom)}, 16);
      check("txn_wrap", 64'(txn_count), 64'(start_txn));
    end

    check("strobe_err_overlap", 64'(both_cnt), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
